// File: rtl/ula_controlador_if.sv
//==============================================================================
// Module : ula_controlador_if
// Brief  : Command, response, ULA and status bundle for the ULA controller.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ula_controlador_if #(
    parameter int BITS = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [BITS-1:0] cmd_data;

    logic [BITS-1:0] ula_a;
    logic [BITS-1:0] ula_b;
    logic [1:0]      ula_f;
    logic [BITS-1:0] ula_saida;
    logic            ula_flag_o;

    logic            res_valid;
    logic            res_ready;
    logic [BITS-1:0] res_data;
    logic            res_ovf;

    logic [BITS-1:0] acc;
    logic            ovf_sticky;
    logic [BITS-1:0] op_count;

    // Environment side: command source, response consumer and the ULA itself.
    modport master (
        output cmd_valid, cmd_op, cmd_data, res_ready, ula_saida, ula_flag_o,
        input  cmd_ready, ula_a, ula_b, ula_f, res_valid, res_data, res_ovf,
               acc, ovf_sticky, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, res_ready, ula_saida, ula_flag_o,
        output cmd_ready, ula_a, ula_b, ula_f, res_valid, res_data, res_ovf,
               acc, ovf_sticky, op_count
    );
endinterface

`default_nettype wire

// File: rtl/ula_controlador.sv
//==============================================================================
// Module : ula_controlador
// Brief  : Sequences accumulator commands onto an external combinational ULA.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ula_controlador #(
    parameter int BITS = 8
) (
    input  wire logic           clock,
    input  wire logic           reset,
    ula_controlador_if.slave    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [1:0] c_SUB_LOAD    = 2'b00;
    localparam logic [1:0] c_SUB_CLRFLAG = 2'b01;

    logic [1:0]      r_state;
    logic [BITS-1:0] r_acc;
    logic [BITS-1:0] r_ula_a;
    logic [BITS-1:0] r_ula_b;
    logic [1:0]      r_ula_f;
    logic [BITS-1:0] r_res_data;
    logic            r_res_ovf;
    logic            r_ovf_sticky;
    logic [BITS-1:0] r_op_count;

    logic w_accept;
    logic w_is_ula_op;

    // Ready is masked by reset so a source never sees an accept while held in reset.
    assign w_accept    = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_is_ula_op = ~bus.cmd_op[2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_ula_a      <= '0;
            r_ula_b      <= '0;
            r_ula_f      <= 2'b00;
            r_res_data   <= '0;
            r_res_ovf    <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_ula_op) begin
                            r_ula_a <= r_acc;
                            r_ula_b <= bus.cmd_data;
                            r_ula_f <= bus.cmd_op[1:0];
                            r_state <= ST_ISSUE;
                        end else begin
                            r_res_ovf <= 1'b0;
                            r_state   <= ST_RESP;
                            case (bus.cmd_op[1:0])
                                c_SUB_LOAD: begin
                                    r_acc      <= bus.cmd_data;
                                    r_res_data <= bus.cmd_data;
                                end
                                c_SUB_CLRFLAG: begin
                                    r_ovf_sticky <= 1'b0;
                                    r_res_data   <= r_acc;
                                end
                                default: begin
                                    r_res_data <= r_acc;
                                end
                            endcase
                        end
                    end
                end

                // The ULA is combinational, so its outputs are valid one cycle after A/B/F load.
                ST_ISSUE: begin
                    r_acc        <= bus.ula_saida;
                    r_res_data   <= bus.ula_saida;
                    r_res_ovf    <= bus.ula_flag_o;
                    r_ovf_sticky <= r_ovf_sticky | bus.ula_flag_o;
                    r_op_count   <= r_op_count + 1'b1;
                    r_state      <= ST_RESP;
                end

                ST_RESP: begin
                    if (bus.res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE) && reset;
    assign bus.res_valid  = (r_state == ST_RESP);
    assign bus.ula_a      = r_ula_a;
    assign bus.ula_b      = r_ula_b;
    assign bus.ula_f      = r_ula_f;
    assign bus.res_data   = r_res_data;
    assign bus.res_ovf    = r_res_ovf;
    assign bus.acc        = r_acc;
    assign bus.ovf_sticky = r_ovf_sticky;
    assign bus.op_count   = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_ula_controlador.sv
//==============================================================================
// Module : tb_ula_controlador
// Brief  : Directed scoreboard bench for ula_controlador with a behavioural ULA.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ula_controlador;

    localparam int BITS = 8;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       sticky;
        logic [7:0] count;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    exp_t sb_q[$];

    ula_controlador_if #(.BITS(BITS)) bus ();

    ula_controlador #(.BITS(BITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ULA: AND, OR, ADD, SUB with two's-complement overflow on ADD/SUB only.
    logic [7:0] ula_sum;
    logic [7:0] ula_dif;
    always_comb begin
        ula_sum        = bus.ula_a + bus.ula_b;
        ula_dif        = bus.ula_a - bus.ula_b;
        bus.ula_saida  = 8'h00;
        bus.ula_flag_o = 1'b0;
        case (bus.ula_f)
            2'b00: bus.ula_saida = bus.ula_a & bus.ula_b;
            2'b01: bus.ula_saida = bus.ula_a | bus.ula_b;
            2'b10: begin
                bus.ula_saida  = ula_sum;
                bus.ula_flag_o = (bus.ula_a[7] == bus.ula_b[7]) && (ula_sum[7] != bus.ula_a[7]);
            end
            default: begin
                bus.ula_saida  = ula_dif;
                bus.ula_flag_o = (bus.ula_a[7] != bus.ula_b[7]) && (ula_dif[7] != bus.ula_a[7]);
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one comparison set per completed response handshake.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset && bus.res_valid && bus.res_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_response", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("res_data",   {24'd0, bus.res_data}, {24'd0, e.data});
                    check("res_ovf",    {31'd0, bus.res_ovf},  {31'd0, e.ovf});
                    check("ovf_sticky", {31'd0, bus.ovf_sticky}, {31'd0, e.sticky});
                    check("op_count",   {24'd0, bus.op_count}, {24'd0, e.count});
                end
            end
        end
    end

    // Drives one command and checks accept-to-valid latency; hold delays res_ready.
    task automatic send(input logic [2:0] op, input logic [7:0] data,
                        input logic [7:0] e_data, input logic e_ovf,
                        input logic e_sticky, input logic [7:0] e_count,
                        input int hold);
        exp_t e;
        int   wait_cnt;
        int   lat;
        e.data   = e_data;
        e.ovf    = e_ovf;
        e.sticky = e_sticky;
        e.count  = e_count;
        sb_q.push_back(e);
        @(negedge clock);
        bus.res_ready = (hold == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        wait_cnt = 0;
        while (!bus.cmd_ready && wait_cnt < 20) begin
            @(negedge clock);
            wait_cnt++;
        end
        if (wait_cnt >= 20) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clock);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_data  = 8'($urandom);
        lat = 1;
        while (!bus.res_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, op[2] ? 32'd1 : 32'd2);
        for (int h = 0; h < hold; h++) begin
            #1;
            check("hold_valid",   {31'd0, bus.res_valid}, 32'd1);
            check("hold_data",    {24'd0, bus.res_data},  {24'd0, e_data});
            check("hold_cmd_rdy", {31'd0, bus.cmd_ready}, 32'd0);
            @(negedge clock);
        end
        bus.res_ready = 1'b1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 8'h00;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_acc",       {24'd0, bus.acc},        32'd0);
        check("rst_op_count",  {24'd0, bus.op_count},   32'd0);
        check("rst_sticky",    {31'd0, bus.ovf_sticky}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid},  32'd0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready},  32'd1);
        check("rst_ula_a",     {24'd0, bus.ula_a},      32'd0);
        check("rst_ula_f",     {30'd0, bus.ula_f},      32'd0);

        // 100 + 50 overflows to -106
        send(3'b100, 8'd100, 8'd100, 1'b0, 1'b0, 8'd0, 0);
        send(3'b010, 8'd50,  8'h96,  1'b1, 1'b1, 8'd1, 0);
        check("acc_after_add", {24'd0, bus.acc}, 32'h96);

        // -128 - 1 overflows to 127; CLRFLAG clears sticky
        send(3'b100, 8'h80, 8'h80, 1'b0, 1'b1, 8'd1, 0);
        send(3'b011, 8'h01, 8'h7F, 1'b1, 1'b1, 8'd2, 0);
        send(3'b101, 8'h00, 8'h7F, 1'b0, 1'b0, 8'd2, 0);

        send(3'b100, 8'hF0, 8'hF0, 1'b0, 1'b0, 8'd2, 0);
        send(3'b000, 8'h3C, 8'h30, 1'b0, 1'b0, 8'd3, 0);
        check("ula_f_and", {30'd0, bus.ula_f}, 32'd0);
        send(3'b001, 8'h0F, 8'h3F, 1'b0, 1'b0, 8'd4, 0);
        check("ula_f_or", {30'd0, bus.ula_f}, 32'd1);
        send(3'b110, 8'h55, 8'h3F, 1'b0, 1'b0, 8'd4, 0);
        send(3'b111, 8'hAA, 8'h3F, 1'b0, 1'b0, 8'd4, 0);

        // Backpressure: 0x3F + 5 = 0x44 held for five cycles
        send(3'b010, 8'd5, 8'h44, 1'b0, 1'b0, 8'd5, 5);
        check("ula_a_hold", {24'd0, bus.ula_a}, 32'h3F);
        check("ula_b_hold", {24'd0, bus.ula_b}, 32'h05);

        // Reset during ISSUE of ADD 7 with acc=3
        send(3'b100, 8'd3, 8'd3, 1'b0, 1'b0, 8'd5, 0);
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b010;
        bus.cmd_data  = 8'd7;
        @(posedge clock);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        reset         = 1'b0;
        #1;
        check("mid_rst_acc",       {24'd0, bus.acc},        32'd0);
        check("mid_rst_res_valid", {31'd0, bus.res_valid},  32'd0);
        check("mid_rst_res_data",  {24'd0, bus.res_data},   32'd0);
        check("mid_rst_ula_b",     {24'd0, bus.ula_b},      32'd0);
        check("mid_rst_ula_f",     {30'd0, bus.ula_f},      32'd0);
        check("mid_rst_op_count",  {24'd0, bus.op_count},   32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("post_rst_no_resp", {31'd0, bus.res_valid}, 32'd0);
        end
        check("post_rst_acc", {24'd0, bus.acc}, 32'd0);

        // 256 ADD 0 operations wrap the counter back to zero
        for (int i = 1; i <= 256; i++) begin
            send(3'b010, 8'd0, 8'd0, 1'b0, 1'b0, 8'(i), 0);
        end
        send(3'b100, 8'd9, 8'd9, 1'b0, 1'b0, 8'd0, 0);
        send(3'b110, 8'd0, 8'd9, 1'b0, 1'b0, 8'd0, 0);
        send(3'b101, 8'd0, 8'd9, 1'b0, 1'b0, 8'd0, 0);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
